regfile_sequencer: RTL and testbench
====================================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: address bits; the target register file has 2^N registers.
REQ-002 SHALL have parameter W, default 8, legal range 4..16: word width and LFSR width.
REQ-003 SHALL have parameter SEED, default 1: W-bit initial LFSR value; nonzero.
REQ-004 SHALL have port clk  input  1: single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1: one-cycle pulse that starts a fill pass.
REQ-007 SHALL have port next  input  1: one-cycle pulse that advances the read pointer.
REQ-008 SHALL have port we  output  1: register-file write enable.
REQ-009 SHALL have port addr_rd  output  N: register-file write address.
REQ-010 SHALL have port data_in  output  W: register-file write data.
REQ-011 SHALL have ports addr_rs1 and addr_rs2  output  N each: register-file read addresses.
REQ-012 SHALL have ports rs1 and rs2  input  W each: combinational read data returned by the register file.
REQ-013 SHALL have ports rd1_q and rd2_q  output  W each: captured read data.
REQ-014 SHALL have port busy  output  1: high in FILL and CHECK.
REQ-015 SHALL have port err  output  1: sticky readback-mismatch flag, present only with the macro in REQ-031.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, CHECK and READ.
REQ-017 SHALL implement a W-bit Fibonacci LFSR that shifts left; feedback is the XOR of the package tap mask for W; for W=8 the taps are bits 7, 5, 4 and 3.
REQ-018 On start in IDLE or READ, SHALL latch fill_seed equal to the current LFSR value and enter FILL on the next cycle.
REQ-019 In FILL, SHALL drive we=1, addr_rd=k and data_in=LFSR for k = 1..2^N-1, one write per cycle; register 0 is never written.
REQ-020 In FILL, SHALL advance the LFSR once per write; a pass takes exactly 2^N-1 cycles.
REQ-021 After the write to address 2^N-1, SHALL go to CHECK when the macro is defined, else to READ.
REQ-022 SHALL drive we=0 in every state other than FILL.
REQ-023 In READ, addr_rs1 SHALL equal ptr and addr_rs2 SHALL equal (ptr+1) mod 2^N.
REQ-024 ptr SHALL be 0 on entry to READ.
REQ-025 On next in READ, ptr SHALL increment and wrap from 2^N-1 to 0.
REQ-026 rd1_q and rd2_q SHALL register rs1 and rs2 every cycle in READ, giving 1-cycle latency from address to data; they SHALL hold their values in all other states.
REQ-027 SHALL ignore start and next in FILL and CHECK.
REQ-028 SHALL ignore next in IDLE.
REQ-029 If start and next are both high in READ, start SHALL win.
REQ-030 The LFSR SHALL continue from its current state across passes, so successive passes write new values.

Configuration
REQ-031 With REGFILE_SEQ_CHECK_EN defined, CHECK SHALL reload the LFSR with fill_seed, walk addr_rs1 over 1..2^N-1 one per cycle, compare rs1 with the LFSR, and set err on any mismatch, then enter READ.
REQ-032 With REGFILE_SEQ_CHECK_EN defined, err SHALL be cleared only by reset or by the start of a new FILL.
REQ-033 Without REGFILE_SEQ_CHECK_EN, the CHECK state, fill_seed compare logic and err port SHALL be absent.

Reset
REQ-034 While rst_n is low, SHALL set the state to IDLE, LFSR=SEED, ptr=0, all address outputs 0, data_in=0, we=0, rd1_q=rd2_q=0, busy=0 and err=0.
REQ-035 Reset asserted mid-FILL SHALL drop we in the same cycle, asynchronously.

Structure
REQ-036 The package regfile_seq_pkg SHALL hold the state enum and the tap-mask lookup for W=4..16.
REQ-037 The LFSR SHALL be a sub-module named lfsr_gen, with ports load, load_val, step and q.

Verification
REQ-038 N=4, W=8, SEED=0x01, start pulse -> writes reg1..reg5 = 0x01, 0x02, 0x04, 0x08, 0x11; we high for exactly 15 cycles.
REQ-039 Pass end, then three next pulses -> rd1_q/rd2_q show reg3/reg4; then ptr=15 followed by next -> ptr=0, rd1_q=0x00.
REQ-040 start pulse during FILL -> ignored; total writes remain 15.
REQ-041 start and next in the same READ cycle -> FILL entered; ptr unchanged until FILL completes.
REQ-042 rst_n pulsed low at the 7th FILL cycle -> we=0 immediately; all outputs at their REQ-034 values.
REQ-043 With REGFILE_SEQ_CHECK_EN, a bench model corrupts reg9 -> err=1 after CHECK; err stays 1 until the next start.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared types for the register-file fill/check/read sequencer:
// the sequencer state encoding and the LFSR tap-mask lookup.
package regfile_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  // Maximal-length Fibonacci taps for a left-shifting LFSR.
  // A set bit marks a state bit that is XORed into the new bit 0.
  function automatic logic [15:0] tap_mask(input int unsigned w);
    logic [15:0] m;
    case (w)
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h00B8;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/regfile_sequencer_lfsr.sv
// W-bit Fibonacci LFSR shifting left; load has priority over step.
module lfsr_gen
  import regfile_seq_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] SEED = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] q
);

  localparam logic [15:0]  TAPS_FULL = tap_mask(W);
  localparam logic [W-1:0] TAPS      = TAPS_FULL[W-1:0];

  logic feedback;

  assign feedback = ^(q & TAPS);

  // LFSR state: reload, advance, or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= {q[W-2:0], feedback};
    end
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Register-file sequencer: fills registers 1..2^N-1 with LFSR words,
// optionally reads them back for verification, then serves paired reads.
// Optional readback check enabled by defining REGFILE_SEQ_CHECK_EN.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int           N    = 4,
  parameter int           W    = 8,
  parameter logic [W-1:0] SEED = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         next,
  output logic         we,
  output logic [N-1:0] addr_rd,
  output logic [W-1:0] data_in,
  output logic [N-1:0] addr_rs1,
  output logic [N-1:0] addr_rs2,
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  output logic [W-1:0] rd1_q,
  output logic [W-1:0] rd2_q,
  output logic         busy
`ifdef REGFILE_SEQ_CHECK_EN
  ,
  output logic         err
`endif
);

  localparam logic [N-1:0] LAST = '1;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  state_e       state;
  logic [N-1:0] k;
  logic [N-1:0] ptr;
  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_load_val;
  logic         lfsr_load;
  logic         lfsr_step;
  logic         start_ok;
  logic         fill_last;

  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_READ));
  assign fill_last = (state == ST_FILL) && (k == LAST);
  assign busy      = (state == ST_FILL) || (state == ST_CHECK);

`ifdef REGFILE_SEQ_CHECK_EN
  logic [W-1:0] fill_seed;

  // The readback walk regenerates the pass from its seed, so rewind the
  // LFSR on the final write; after the walk it lands where FILL left it.
  assign lfsr_load     = fill_last;
  assign lfsr_load_val = fill_seed;
  assign lfsr_step     = (state == ST_FILL) || (state == ST_CHECK);

  // Capture the pass seed and track sticky readback mismatches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_seed <= '0;
      err       <= 1'b0;
    end else if (start_ok) begin
      fill_seed <= lfsr_q;
      err       <= 1'b0;
    end else if ((state == ST_CHECK) && (rs1 != lfsr_q)) begin
      err <= 1'b1;
    end
  end
`else
  assign lfsr_load     = 1'b0;
  assign lfsr_load_val = '0;
  assign lfsr_step     = (state == ST_FILL);
`endif

  lfsr_gen #(
    .W    (W),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .step     (lfsr_step),
    .q        (lfsr_q)
  );

  // Sequencer FSM with its write index and read pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      k     <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FILL;
            k     <= ONE;
          end
        end
        ST_FILL: begin
          if (k == LAST) begin
`ifdef REGFILE_SEQ_CHECK_EN
            state <= ST_CHECK;
            k     <= ONE;
`else
            state <= ST_READ;
            ptr   <= '0;
`endif
          end else begin
            k <= k + ONE;
          end
        end
`ifdef REGFILE_SEQ_CHECK_EN
        ST_CHECK: begin
          if (k == LAST) begin
            state <= ST_READ;
            ptr   <= '0;
          end else begin
            k <= k + ONE;
          end
        end
`endif
        ST_READ: begin
          if (start) begin
            state <= ST_FILL;
            k     <= ONE;
          end else if (next) begin
            ptr <= ptr + ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register-file port drive; everything idles at zero outside its state
  always_comb begin
    we       = 1'b0;
    addr_rd  = '0;
    data_in  = '0;
    addr_rs1 = '0;
    addr_rs2 = '0;
    case (state)
      ST_FILL: begin
        we      = 1'b1;
        addr_rd = k;
        data_in = lfsr_q;
      end
`ifdef REGFILE_SEQ_CHECK_EN
      ST_CHECK: addr_rs1 = k;
`endif
      ST_READ: begin
        addr_rs1 = ptr;
        addr_rs2 = ptr + ONE;
      end
      default: ;
    endcase
  end

  // Read data capture: sample every READ cycle, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else if (state == ST_READ) begin
      rd1_q <= rs1;
      rd2_q <= rs2;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer (N=4, W=8, SEED=1). Honours
// REGFILE_SEQ_CHECK_EN when defined for the build.
module tb_regfile_sequencer;

  localparam int N = 4;
  localparam int W = 8;
  localparam int R = 16;
`ifdef REGFILE_SEQ_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_FILL = 1, M_CHECK = 2, M_READ = 3;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         next  = 1'b0;
  logic         we;
  logic [N-1:0] addr_rd, addr_rs1, addr_rs2;
  logic [W-1:0] data_in, rs1, rs2, rd1_q, rd2_q;
  logic         busy;
`ifdef REGFILE_SEQ_CHECK_EN
  logic         err;
`endif

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  bit corrupt = 1'b0;
  logic [W-1:0] mem [R] = '{default: '0};

  // Reference model state
  int         m_mode, m_k, m_ptr;
  logic [7:0] m_lfsr, m_seed, m_rd1, m_rd2;
  bit         m_err;

  always #5 clk = ~clk;

  regfile_sequencer #(.N(N), .W(W), .SEED(8'h01)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .next     (next),
    .we       (we),
    .addr_rd  (addr_rd),
    .data_in  (data_in),
    .addr_rs1 (addr_rs1),
    .addr_rs2 (addr_rs2),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd1_q    (rd1_q),
    .rd2_q    (rd2_q),
    .busy     (busy)
`ifdef REGFILE_SEQ_CHECK_EN
    ,
    .err      (err)
`endif
  );

  // Register file with combinational reads; optional corruption of reg9
  assign rs1 = mem[addr_rs1];
  assign rs2 = mem[addr_rs2];
  always @(posedge clk) begin
    if (we) mem[addr_rd] <= (corrupt && addr_rd == 4'd9) ? (data_in ^ 8'hFF) : data_in;
  end

  // LFSR word n steps after v, taps at bits 7,5,4,3
  function automatic logic [7:0] adv(input logic [7:0] v, input int n);
    logic [7:0] x;
    x = v;
    for (int i = 0; i < n; i++) x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_k = 0; m_ptr = 0;
    m_lfsr = 8'h01; m_seed = 8'h00; m_rd1 = 8'h00; m_rd2 = 8'h00; m_err = 1'b0;
  endtask

  task automatic model_advance();
    case (m_mode)
      M_IDLE, M_READ: begin
        if (m_mode == M_READ) begin
          m_rd1 = mem[m_ptr];
          m_rd2 = mem[(m_ptr + 1) % R];
        end
        if (start) begin
          m_seed = m_lfsr; m_mode = M_FILL; m_k = 1; m_err = 1'b0;
        end else if (next && m_mode == M_READ) begin
          m_ptr = (m_ptr + 1) % R;
        end
      end
      M_FILL: begin
        if (m_k == R - 1) begin
          m_lfsr = adv(m_seed, R - 1);
          if (CHK_EN) begin m_mode = M_CHECK; m_k = 1; end
          else begin m_mode = M_READ; m_ptr = 0; end
        end else m_k++;
      end
      default: begin
        if (mem[m_k] != adv(m_seed, m_k - 1)) m_err = 1'b1;
        if (m_k == R - 1) begin m_mode = M_READ; m_ptr = 0; end
        else m_k++;
      end
    endcase
  endtask

  // Cycle compare against the model on the falling edge
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      if (we) wr_count++;
      chk("we", we, m_mode == M_FILL);
      chk("addr_rd", addr_rd, (m_mode == M_FILL) ? m_k : 0);
      chk("data_in", data_in, (m_mode == M_FILL) ? int'(adv(m_seed, m_k - 1)) : 0);
      chk("addr_rs1", addr_rs1, (m_mode == M_READ) ? m_ptr : (m_mode == M_CHECK) ? m_k : 0);
      chk("addr_rs2", addr_rs2, (m_mode == M_READ) ? (m_ptr + 1) % R : 0);
      chk("busy", busy, (m_mode == M_FILL) || (m_mode == M_CHECK));
      chk("rd1_q", rd1_q, m_rd1);
      chk("rd2_q", rd2_q, m_rd2);
`ifdef REGFILE_SEQ_CHECK_EN
      chk("err", err, m_err);
`endif
      if (rst_n) model_advance();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_next();
    next = 1'b1; tick(); next = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      tick();
    end
    chk("busy_timeout", busy, 0);
  endtask

  logic [7:0] first5 [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd1", rd1_q, 0);
    chk("rst_addr_rs1", addr_rs1, 0);
    chk("rst_data_in", data_in, 0);
    rst_n = 1'b1;
    tick(); tick();

    // First pass and literal register contents
    wr_count = 0;
    pulse_start();
    wait_idle();
    chk("wr_pass1", wr_count, 15);
    for (int i = 0; i < 5; i++) chk($sformatf("reg%0d", i + 1), mem[i + 1], first5[i]);

    // Pointer walk and wrap
    repeat (3) pulse_next();
    tick();
    chk("rd1_reg3", rd1_q, 8'h04);
    chk("rd2_reg4", rd2_q, 8'h08);
    repeat (12) pulse_next();
    tick();
    chk("ptr15", addr_rs1, 15);
    chk("ptr15_rd2", rd2_q, 0);
    pulse_next();
    tick();
    chk("wrap_ptr", addr_rs1, 0);
    chk("wrap_rd1", rd1_q, 0);

    // start during FILL is ignored
    wr_count = 0;
    pulse_start();
    repeat (3) tick();
    pulse_start();
    wait_idle();
    chk("wr_start_in_fill", wr_count, 15);

    // start and next together: start wins
    pulse_next(); pulse_next();
    chk("ptr2", addr_rs1, 2);
    wr_count = 0;
    start = 1'b1; next = 1'b1;
    tick();
    start = 1'b0; next = 1'b0;
    chk("sn_busy", busy, 1);
    wait_idle();
    chk("sn_writes", wr_count, 15);
    chk("sn_ptr0", addr_rs1, 0);

    // Reset in the 7th FILL cycle
    pulse_start();
    repeat (6) tick();
    chk("fill7_we", we, 1);
    chk("fill7_addr", addr_rd, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr_rd", addr_rd, 0);
    chk("arst_data_in", data_in, 0);
    chk("arst_rd1", rd1_q, 0);
    chk("arst_rd2", rd2_q, 0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    wait_idle();
    chk("reg1_after_rst", mem[1], 8'h01);
    chk("reg5_after_rst", mem[5], 8'h11);

    // Randomized control pulses
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom_range(0, 30) == 0);
      next  = ($urandom_range(0, 3) == 0);
      tick();
    end
    start = 1'b0; next = 1'b0;
    tick();
    wait_idle();

`ifdef REGFILE_SEQ_CHECK_EN
    // Corrupted reg9 is caught and the flag stays until the next start
    corrupt = 1'b1;
    pulse_start();
    wait_idle();
    corrupt = 1'b0;
    chk("err_set", err, 1);
    repeat (5) tick();
    chk("err_sticky", err, 1);
    pulse_start();
    chk("err_clear", err, 0);
    wait_idle();
    chk("err_clean_pass", err, 0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
